// File: rtl/store_buffer_pkg.sv
// Shared constants for the posted-write store buffer: default widths and
// the request-type encoding carried on req_we.
package store_buffer_pkg;

    localparam int WORD_SIZE_DEF = 32;
    localparam int SB_DEPTH_DEF  = 4;

    typedef enum logic {
        REQ_LOAD  = 1'b0,
        REQ_STORE = 1'b1
    } req_type_e;

endpackage

// File: rtl/store_buffer_match.sv
// Age-priority lookup: finds the youngest valid buffer entry whose address
// equals the lookup address, scanning from the oldest slot toward the tail.
module sb_match #(
    parameter int WORD_SIZE = 32,
    parameter int SB_DEPTH  = 4,
    localparam int PTR_W    = $clog2(SB_DEPTH)
) (
    input  logic [WORD_SIZE-1:0] i_lookup_addr,
    input  logic [WORD_SIZE-1:0] i_entry_addr [SB_DEPTH],
    input  logic [WORD_SIZE-1:0] i_entry_data [SB_DEPTH],
    input  logic [SB_DEPTH-1:0]  i_valid,
    input  logic [PTR_W-1:0]     i_tail,
    output logic                 o_hit,
    output logic [WORD_SIZE-1:0] o_data
);

    logic [PTR_W-1:0] w_idx;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        o_hit  = 1'b0;
        o_data = '0;
        w_idx  = '0;
        // k = SB_DEPTH is the oldest possible slot, k = 1 the youngest; later matches override.
        for (int k = SB_DEPTH; k >= 1; k--) begin
            w_idx = i_tail - PTR_W'(k);
            if (i_valid[w_idx] && (i_entry_addr[w_idx] == i_lookup_addr)) begin
                o_hit  = 1'b1;
                o_data = i_entry_data[w_idx];
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// Posted-write store buffer owning the single data-memory port: stores are
// queued and drained in the background, loads forward from the youngest match.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int WORD_SIZE = WORD_SIZE_DEF,
    parameter int SB_DEPTH  = SB_DEPTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    input  logic                 req_we,
    input  logic [WORD_SIZE-1:0] req_addr,
    input  logic [WORD_SIZE-1:0] req_wdata,
    input  logic                 flush,
    output logic                 stall,
    output logic                 rd_valid,
    output logic [WORD_SIZE-1:0] rd_data,
    output logic                 mem_we,
    output logic [WORD_SIZE-1:0] mem_a,
    output logic [WORD_SIZE-1:0] mem_wd,
    input  logic [WORD_SIZE-1:0] mem_rd,
    output logic                 sb_empty
);

    localparam int PTR_W = $clog2(SB_DEPTH);
    localparam int CNT_W = $clog2(SB_DEPTH + 1);

    logic [WORD_SIZE-1:0] r_addr [SB_DEPTH];
    logic [WORD_SIZE-1:0] r_data [SB_DEPTH];
    logic [PTR_W-1:0]     r_head, r_tail;
    logic [CNT_W-1:0]     r_count;
    logic [WORD_SIZE-1:0] r_mem_a, r_mem_wd, r_hit_data;
    logic                 r_rd_valid, r_rd_miss;

    logic [SB_DEPTH-1:0]  w_valid;
    logic                 w_hit, w_full, w_empty, w_is_load, w_is_store;
    logic                 w_stall, w_accept, w_miss_acc, w_hit_acc, w_push, w_pop;
    logic [WORD_SIZE-1:0] w_hit_data;

    // An entry is live when its distance from head is below the occupancy count.
    always_comb begin
        w_valid = '0;
        for (int i = 0; i < SB_DEPTH; i++) begin
            w_valid[i] = CNT_W'(PTR_W'(PTR_W'(i) - r_head)) < r_count;
        end
    end

    sb_match #(
        .WORD_SIZE (WORD_SIZE),
        .SB_DEPTH  (SB_DEPTH)
    ) u_match (
        .i_lookup_addr (req_addr),
        .i_entry_addr  (r_addr),
        .i_entry_data  (r_data),
        .i_valid       (w_valid),
        .i_tail        (r_tail),
        .o_hit         (w_hit),
        .o_data        (w_hit_data)
    );

    assign w_full     = (r_count == CNT_W'(SB_DEPTH));
    assign w_empty    = (r_count == '0);
    assign w_is_load  = req_valid && (req_we == REQ_LOAD);
    assign w_is_store = req_valid && (req_we == REQ_STORE);

    // Nothing is accepted or drained in a reset cycle, so pending stores are dropped.
    assign w_stall    = !rst && ((flush && !w_empty) || (w_is_load && !w_hit && w_full));
    assign w_accept   = !rst && req_valid && !w_stall;
    assign w_miss_acc = w_accept && w_is_load && !w_hit;
    assign w_hit_acc  = w_accept && w_is_load && w_hit;
    assign w_push     = w_accept && w_is_store;
    assign w_pop      = !rst && !w_miss_acc && !w_empty;

    always_comb begin
        mem_we = 1'b0;
        mem_a  = r_mem_a;
        mem_wd = r_mem_wd;
        if (w_miss_acc) begin
            mem_a = req_addr;
        end else if (w_pop) begin
            mem_we = 1'b1;
            mem_a  = r_addr[r_head];
            mem_wd = r_data[r_head];
        end
    end

    // NOTE: the entry storage has no reset; liveness comes from head/count alone.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr[r_tail] <= req_addr;
            r_data[r_tail] <= req_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_mem_a    <= '0;
            r_mem_wd   <= '0;
            r_rd_valid <= 1'b0;
            r_rd_miss  <= 1'b0;
            r_hit_data <= '0;
        end else begin
            if (w_push) r_tail <= r_tail + PTR_W'(1);
            if (w_pop)  r_head <= r_head + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            r_mem_a    <= mem_a;
            r_mem_wd   <= mem_wd;
            r_rd_valid <= w_hit_acc || w_miss_acc;
            r_rd_miss  <= w_miss_acc;
            if (w_hit_acc) r_hit_data <= w_hit_data;
        end
    end

    assign stall    = w_stall;
    assign rd_valid = r_rd_valid;
    assign rd_data  = r_rd_miss ? mem_rd : r_hit_data;
    assign sb_empty = w_empty;

endmodule

// File: tb/tb_store_buffer.sv
// Randomized bench for store_buffer: a queue-based model of pending stores and
// a golden memory image predict every port, stall and load result.
module tb_store_buffer;

    localparam int W = 32;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         rst, req_valid, req_we, flush;
    logic [W-1:0] req_addr, req_wdata;
    logic         stall, rd_valid, mem_we, sb_empty;
    logic [W-1:0] rd_data, mem_a, mem_wd, mem_rd;

    store_buffer #(.WORD_SIZE(W), .SB_DEPTH(D)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .flush     (flush),
        .stall     (stall),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .mem_we    (mem_we),
        .mem_a     (mem_a),
        .mem_wd    (mem_wd),
        .mem_rd    (mem_rd),
        .sb_empty  (sb_empty)
    );

    always #5 clk = ~clk;

    // Data memory: 16 words, registered read, initialised while mem_init is high.
    logic         mem_init;
    logic [W-1:0] mem [16];
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 16; i++) mem[i] <= (i == 3) ? 32'h33 : 32'h1000 + i;
        end else if (mem_we) begin
            mem[mem_a[3:0]] <= mem_wd;
        end
        mem_rd <= mem[mem_a[3:0]];
    end

    typedef struct {
        logic [W-1:0] addr;
        logic [W-1:0] data;
    } st_t;

    st_t          sbq [$];
    logic [W-1:0] ref_mem [16];
    logic         exp_rv, chk_zero;
    logic [W-1:0] exp_rd, last_a, last_wd;
    int           n_checks = 0;
    int           n_pass   = 0;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    task automatic step(input logic v, input logic we, input logic [W-1:0] a,
                        input logic [W-1:0] d, input logic fl, input logic r);
        logic         hit, is_load, exp_stall, acc, miss;
        logic [W-1:0] hd;
        @(negedge clk);
        req_valid = v; req_we = we; req_addr = a; req_wdata = d; flush = fl; rst = r;
        #1;
        check("rd_valid", {31'b0, rd_valid}, {31'b0, exp_rv});
        if (exp_rv || chk_zero) check("rd_data", rd_data, exp_rd);
        chk_zero = 1'b0;
        check("sb_empty", {31'b0, sb_empty}, {31'b0, sbq.size() == 0});
        check("count", W'(dut.r_count), W'(sbq.size()));
        if (r) begin
            sbq.delete();
            exp_rv = 1'b0; exp_rd = '0; last_a = '0; last_wd = '0; chk_zero = 1'b1;
        end else begin
            hit = 1'b0; hd = '0;
            foreach (sbq[i]) if (sbq[i].addr == a) begin hit = 1'b1; hd = sbq[i].data; end
            is_load   = v && !we;
            exp_stall = (fl && sbq.size() != 0) || (is_load && !hit && sbq.size() == D);
            check("stall", {31'b0, stall}, {31'b0, exp_stall});
            acc  = v && !exp_stall;
            miss = acc && is_load && !hit;
            if (miss) begin
                check("mem_we", {31'b0, mem_we}, '0);
                check("mem_a_load", mem_a, a);
                last_a = a;
                hd = ref_mem[a[3:0]];
            end else if (sbq.size() > 0) begin
                check("mem_we", {31'b0, mem_we}, 32'd1);
                check("mem_a_drain", mem_a, sbq[0].addr);
                check("mem_wd_drain", mem_wd, sbq[0].data);
                ref_mem[sbq[0].addr[3:0]] = sbq[0].data;
                last_a = sbq[0].addr; last_wd = sbq[0].data;
                void'(sbq.pop_front());
            end else begin
                check("mem_we", {31'b0, mem_we}, '0);
                check("mem_a_hold", mem_a, last_a);
                check("mem_wd_hold", mem_wd, last_wd);
            end
            if (acc && we) sbq.push_back('{addr: a, data: d});
            exp_rv = acc && is_load;
            exp_rd = hd;
        end
    endtask

    initial begin
        rst = 1'b1; mem_init = 1'b1; flush = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        for (int i = 0; i < 16; i++) ref_mem[i] = (i == 3) ? 32'h33 : 32'h1000 + i;
        repeat (3) @(negedge clk);
        mem_init = 1'b0;
        exp_rv = 1'b0; exp_rd = '0; last_a = '0; last_wd = '0; chk_zero = 1'b1;

        // Store then load of the same address: forwarded, then drained.
        step(1, 1, 5, 32'h11, 0, 0);
        step(1, 0, 5, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        // Back-to-back stores to one address; the load must see the younger one.
        step(1, 1, 7, 32'hAA, 0, 0);
        step(1, 1, 7, 32'hBB, 0, 0);
        step(1, 0, 7, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        check("mem7_final", ref_mem[7], 32'hBB);
        // Miss load from the preloaded word.
        step(1, 0, 3, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        // Stores interleaved with miss loads, then a further miss and a store.
        for (int i = 0; i < 4; i++) begin
            step(1, 1, W'(8 + i), W'(32'hC0 + i), 0, 0);
            step(1, 0, 12, 0, 0, 0);
        end
        step(1, 0, 9, 0, 0, 0);
        step(1, 1, 13, 32'hD0, 0, 0);
        // Flush with pending stores holds off new requests until empty.
        step(1, 1, 14, 32'hE0, 0, 0);
        for (int i = 0; i < 4; i++) step(1, 1, 15, W'(32'hF0 + i), 1, 0);
        step(0, 0, 0, 0, 0, 0);
        // Reset with pending stores drops them; memory keeps its old value.
        step(0, 0, 0, 0, 0, 0);
        step(1, 1, 2, 32'h77, 0, 0);
        step(1, 1, 2, 32'h88, 0, 1);
        step(1, 0, 2, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);

        for (int n = 0; n < 600; n++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, W'($urandom_range(0, 15)),
                 $urandom, $urandom_range(0, 7) == 0, $urandom_range(0, 63) == 0);
        end
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
